// File: rtl/overlay_track_sequencer_pkg.sv
// rtl/overlay_track_sequencer_pkg.sv - shared types and helpers for the overlay track sequencer
package overlay_track_sequencer_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        NO_TARGET = 2'd0,
        ACQUIRE   = 2'd1,
        TRACKING  = 2'd2,
        COAST     = 2'd3
    } track_state_t;

    // Clamp a detector coordinate to the last active pixel of its axis.
    function automatic coord_t clamp_coord(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/overlay_track_sequencer_if.sv
// rtl/overlay_track_sequencer_if.sv - blob-detector result bus into the sequencer
interface overlay_track_sequencer_if;
    import overlay_track_sequencer_pkg::*;

    logic   det_update;
    logic   det_valid;
    coord_t det_cx;
    coord_t det_cy;
    coord_t det_min_x;
    coord_t det_min_y;
    coord_t det_max_x;
    coord_t det_max_y;

    modport master (
        output det_update, det_valid, det_cx, det_cy,
               det_min_x, det_min_y, det_max_x, det_max_y
    );

    modport slave (
        input  det_update, det_valid, det_cx, det_cy,
               det_min_x, det_min_y, det_max_x, det_max_y
    );

endinterface

// File: rtl/overlay_track_sequencer_coord_smoother.sv
// rtl/overlay_track_sequencer_coord_smoother.sv - one-axis IIR centroid smoother
module overlay_track_sequencer_coord_smoother
    import overlay_track_sequencer_pkg::*;
#(
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   step,
    input  coord_t din,
    output coord_t q
);

    logic signed [COORD_W:0] diff;
    logic signed [COORD_W:0] diff_sh;
    logic signed [COORD_W:0] sum;

    // Arithmetic shift floors toward minus infinity; the result always lies between old and new value.
    always_comb begin
        diff    = $signed({1'b0, din}) - $signed({1'b0, q});
        diff_sh = diff >>> SMOOTH_SHIFT;
        sum     = $signed({1'b0, q}) + diff_sh;
    end

    // Direct load on fresh acquisition, filtered step while already tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (step) begin
            q <= sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/overlay_track_sequencer.sv
// rtl/overlay_track_sequencer.sv - frame-synchronous target tracking controller feeding overlay_manager
module overlay_track_sequencer
    import overlay_track_sequencer_pkg::*;
#(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int ACQUIRE_FRAMES = 3,
    parameter int COAST_FRAMES   = 15,
    parameter int SMOOTH_SHIFT   = 2,
    parameter int BLINK_FRAMES   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_end,
    overlay_track_sequencer_if.slave   det,
    input  logic                       sw_overlay_en,
    input  logic                       sw_bbox_en,
    output coord_t                     centroid_x,
    output coord_t                     centroid_y,
    output coord_t                     bbox_min_x,
    output coord_t                     bbox_min_y,
    output coord_t                     bbox_max_x,
    output coord_t                     bbox_max_y,
    output logic                       centroid_valid,
    output logic                       overlay_en,
    output logic                       bbox_en,
    output track_state_t               track_state
);

    typedef logic [7:0] cnt_t;

    localparam coord_t X_MAX     = coord_t'(FRAME_WIDTH - 1);
    localparam coord_t Y_MAX     = coord_t'(FRAME_HEIGHT - 1);
    localparam cnt_t   ACQ_LIM   = cnt_t'(ACQUIRE_FRAMES);
    localparam cnt_t   COAST_LIM = cnt_t'(COAST_FRAMES);
    localparam cnt_t   BLINK_LIM = cnt_t'(BLINK_FRAMES);

    logic   pending;
    logic   sh_valid;
    coord_t sh_cx, sh_cy, sh_min_x, sh_min_y, sh_max_x, sh_max_y;

    track_state_t state, state_nxt;
    cnt_t         acq_cnt, acq_nxt;
    cnt_t         miss_cnt, miss_nxt;
    cnt_t         blink_cnt, blink_cnt_nxt;
    logic         blink_on, blink_on_nxt;
    logic         hit;
    logic         load_c, step_c, load_bbox;

    // Shadow of the latest detector result; a capture in the frame_end cycle counts for the next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            sh_valid <= 1'b0;
            sh_cx    <= '0;
            sh_cy    <= '0;
            sh_min_x <= '0;
            sh_min_y <= '0;
            sh_max_x <= '0;
            sh_max_y <= '0;
        end else if (det.det_update) begin
            pending  <= 1'b1;
            sh_valid <= det.det_valid;
            sh_cx    <= clamp_coord(det.det_cx, X_MAX);
            sh_cy    <= clamp_coord(det.det_cy, Y_MAX);
            sh_min_x <= clamp_coord(det.det_min_x, X_MAX);
            sh_min_y <= clamp_coord(det.det_min_y, Y_MAX);
            sh_max_x <= clamp_coord(det.det_max_x, X_MAX);
            sh_max_y <= clamp_coord(det.det_max_y, Y_MAX);
        end else if (frame_end) begin
            pending  <= 1'b0;
        end
    end

    assign hit = pending & sh_valid;

    // FSM state and per-frame counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= NO_TARGET;
            acq_cnt   <= '0;
            miss_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else begin
            state     <= state_nxt;
            acq_cnt   <= acq_nxt;
            miss_cnt  <= miss_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
        end
    end

    // Next-state logic, evaluated only at frame_end so the track decision is once per frame.
    always_comb begin
        state_nxt     = state;
        acq_nxt       = acq_cnt;
        miss_nxt      = miss_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_on_nxt  = blink_on;
        load_c        = 1'b0;
        step_c        = 1'b0;
        load_bbox     = 1'b0;
        if (frame_end) begin
            unique case (state)
                NO_TARGET: begin
                    if (hit) begin
                        if (ACQ_LIM <= cnt_t'(1)) begin
                            state_nxt = TRACKING;
                            acq_nxt   = '0;
                            load_c    = 1'b1;
                            load_bbox = 1'b1;
                        end else begin
                            state_nxt = ACQUIRE;
                            acq_nxt   = cnt_t'(1);
                        end
                    end
                end
                ACQUIRE: begin
                    if (!hit) begin
                        state_nxt = NO_TARGET;
                        acq_nxt   = '0;
                    end else if (acq_cnt + cnt_t'(1) >= ACQ_LIM) begin
                        state_nxt = TRACKING;
                        acq_nxt   = '0;
                        load_c    = 1'b1;
                        load_bbox = 1'b1;
                    end else begin
                        acq_nxt   = acq_cnt + cnt_t'(1);
                    end
                end
                TRACKING: begin
                    if (hit) begin
                        step_c        = 1'b1;
                        load_bbox     = 1'b1;
                    end else begin
                        state_nxt     = COAST;
                        miss_nxt      = cnt_t'(1);
                        blink_on_nxt  = 1'b1;
                        blink_cnt_nxt = '0;
                    end
                end
                COAST: begin
                    if (hit) begin
                        state_nxt     = TRACKING;
                        miss_nxt      = '0;
                        blink_cnt_nxt = '0;
                        step_c        = 1'b1;
                        load_bbox     = 1'b1;
                    end else if (miss_cnt >= COAST_LIM) begin
                        state_nxt     = NO_TARGET;
                        miss_nxt      = '0;
                        blink_cnt_nxt = '0;
                        blink_on_nxt  = 1'b0;
                    end else begin
                        miss_nxt = miss_cnt + cnt_t'(1);
                        if (blink_cnt + cnt_t'(1) >= BLINK_LIM) begin
                            blink_cnt_nxt = '0;
                            blink_on_nxt  = ~blink_on;
                        end else begin
                            blink_cnt_nxt = blink_cnt + cnt_t'(1);
                        end
                    end
                end
                default: state_nxt = NO_TARGET;
            endcase
        end
    end

    // Committed overlay controls and bounding box, refreshed only at frame_end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            centroid_valid <= 1'b0;
            overlay_en     <= 1'b0;
            bbox_en        <= 1'b0;
            bbox_min_x     <= '0;
            bbox_min_y     <= '0;
            bbox_max_x     <= '0;
            bbox_max_y     <= '0;
        end else if (frame_end) begin
            centroid_valid <= (state_nxt == TRACKING) || (state_nxt == COAST);
            overlay_en     <= sw_overlay_en &&
                              ((state_nxt == TRACKING) || ((state_nxt == COAST) && blink_on_nxt));
            bbox_en        <= sw_bbox_en && (state_nxt == TRACKING);
            if (load_bbox) begin
                bbox_min_x <= sh_min_x;
                bbox_min_y <= sh_min_y;
                bbox_max_x <= sh_max_x;
                bbox_max_y <= sh_max_y;
            end
        end
    end

    assign track_state = state;

    overlay_track_sequencer_coord_smoother #(.SMOOTH_SHIFT(SMOOTH_SHIFT)) u_smooth_x (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .step  (step_c),
        .din   (sh_cx),
        .q     (centroid_x)
    );

    overlay_track_sequencer_coord_smoother #(.SMOOTH_SHIFT(SMOOTH_SHIFT)) u_smooth_y (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_c),
        .step  (step_c),
        .din   (sh_cy),
        .q     (centroid_y)
    );

endmodule
